microwave_timer: RTL and testbench

//   Cook-time countdown for the microwave controller; the time source behind the magnetron latch.

---
 rtl/microwave_timer_pkg.sv | 21 ++
 rtl/microwave_timer_if.sv | 30 +++
 rtl/microwave_timer_bcd_down_digit.sv | 23 ++
 rtl/microwave_timer.sv | 143 ++++++++++++++
 tb/tb_microwave_timer.sv | 193 +++++++++++++++++++
 5 files changed

// File: rtl/microwave_timer_pkg.sv
// Shared types and constants for the microwave cook timer.
package microwave_pkg;

  localparam int BCD_W = 4;

  typedef logic [BCD_W-1:0] bcd_t;

  localparam bcd_t BCD_MAX      = 4'd9;
  localparam bcd_t SEC_TENS_MAX = 4'd5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SET  = 2'd1,
    RUN  = 2'd2
  } state_t;

  function automatic logic bcd_valid(input bcd_t d);
    return d <= BCD_MAX;
  endfunction

endpackage

// File: rtl/microwave_timer_if.sv
// Keypad / magnetron / display bundle between the controller and the cook timer.
interface microwave_timer_if;
  import microwave_pkg::*;

  bcd_t   key_digit;
  logic   key_valid;
  logic   clear;
  logic   mag_on;
  bcd_t   min_tens;
  bcd_t   min_ones;
  bcd_t   sec_tens;
  bcd_t   sec_ones;
  logic   timer_done;
  logic   done_pulse;
  logic   beep;
  state_t state;

  modport master (
    output key_digit, key_valid, clear, mag_on,
    input  min_tens, min_ones, sec_tens, sec_ones,
    input  timer_done, done_pulse, beep, state
  );

  modport slave (
    input  key_digit, key_valid, clear, mag_on,
    output min_tens, min_ones, sec_tens, sec_ones,
    output timer_done, done_pulse, beep, state
  );

endinterface

// File: rtl/microwave_timer_bcd_down_digit.sv
// One BCD digit of the countdown: decrements when enabled, wraps to wrap_val
// and raises borrow_out when stepping down from zero.
module bcd_down_digit
  import microwave_pkg::*;
(
  input  bcd_t digit,
  input  logic dec_en,
  input  bcd_t wrap_val,
  output bcd_t next_digit,
  output logic borrow_out
);

  assign borrow_out = dec_en && (digit == '0);

  // Next value of this digit for the current tick.
  always_comb begin
    next_digit = digit;
    if (dec_en) begin
      next_digit = (digit == '0) ? wrap_val : digit - bcd_t'(1);
    end
  end

endmodule

// File: rtl/microwave_timer.sv
// MM:SS cook-time countdown with keypad entry, BCD display digits and a
// done indication for the magnetron latch.
// Optional buzzer: define MW_BEEP_EN to build the beep timer; otherwise beep
// is tied low and BEEP_CYCLES has no effect.
module microwave_timer
  import microwave_pkg::*;
#(
  parameter int unsigned TICK_DIV    = 50_000_000,
  parameter int unsigned BEEP_CYCLES = 25_000_000
) (
  input  logic              clk,
  input  logic              reset,
  microwave_timer_if.slave  io
);

  localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  bcd_t          m1, m0, s1, s0;
  bcd_t          m1_n, m0_n, s1_n, s0_n;
  logic [PW-1:0] presc;
  logic          done_pulse_q;
  state_t        state;
  logic          time_nz;
  logic          tick;
  logic          key_ok;
  logic          zero_next;
  logic          b_s0, b_s1, b_m0;
  logic          unused_m1_borrow;

  assign time_nz = |{m1, m0, s1, s0};

  // The state is fully determined by the stored time and the magnetron
  // level, so it is decoded rather than stored; pause/resume then needs no
  // extra bookkeeping beyond the held prescaler.
  always_comb begin
    if (!time_nz)        state = IDLE;
    else if (io.mag_on)  state = RUN;
    else                 state = SET;
  end

  assign tick   = (state == RUN) && (presc == PW'(TICK_DIV - 1));
  assign key_ok = io.key_valid && !io.mag_on && bcd_valid(io.key_digit);

  bcd_down_digit u_s0 (
    .digit(s0), .dec_en(tick), .wrap_val(BCD_MAX),
    .next_digit(s0_n), .borrow_out(b_s0)
  );
  bcd_down_digit u_s1 (
    .digit(s1), .dec_en(b_s0), .wrap_val(SEC_TENS_MAX),
    .next_digit(s1_n), .borrow_out(b_s1)
  );
  bcd_down_digit u_m0 (
    .digit(m0), .dec_en(b_s1), .wrap_val(BCD_MAX),
    .next_digit(m0_n), .borrow_out(b_m0)
  );
  bcd_down_digit u_m1 (
    .digit(m1), .dec_en(b_m0), .wrap_val(BCD_MAX),
    .next_digit(m1_n), .borrow_out(unused_m1_borrow)
  );

  assign zero_next = ({m1_n, m0_n, s1_n, s0_n} == '0);

  // Digits, prescaler and done strobe; clear beats tick beats key entry.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      m1           <= '0;
      m0           <= '0;
      s1           <= '0;
      s0           <= '0;
      presc        <= '0;
      done_pulse_q <= 1'b0;
    end else begin
      done_pulse_q <= 1'b0;
      if (io.clear) begin
        m1    <= '0;
        m0    <= '0;
        s1    <= '0;
        s0    <= '0;
        presc <= '0;
      end else begin
        case (state)
          RUN: begin
            presc <= tick ? '0 : presc + PW'(1);
            if (tick) begin
              m1           <= m1_n;
              m0           <= m0_n;
              s1           <= s1_n;
              s0           <= s0_n;
              done_pulse_q <= zero_next;
            end
          end
          default: begin
            if (key_ok) begin
              m1 <= m0;
              m0 <= s1;
              s1 <= s0;
              s0 <= io.key_digit;
            end
          end
        endcase
      end
    end
  end

`ifdef MW_BEEP_EN
  localparam int unsigned BW = (BEEP_CYCLES > 1) ? $clog2(BEEP_CYCLES) : 1;

  logic          beep_q;
  logic [BW-1:0] beep_cnt;

  // Buzzer runs BEEP_CYCLES cycles after each done strobe; any key or clear silences it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      beep_q   <= 1'b0;
      beep_cnt <= '0;
    end else if (io.clear || io.key_valid) begin
      beep_q   <= 1'b0;
      beep_cnt <= '0;
    end else if (done_pulse_q) begin
      beep_q   <= 1'b1;
      beep_cnt <= BW'(BEEP_CYCLES - 1);
    end else if (beep_q) begin
      if (beep_cnt == '0) beep_q <= 1'b0;
      else                beep_cnt <= beep_cnt - BW'(1);
    end
  end

  assign io.beep = beep_q;
`else
  logic unused_beep_cfg;
  assign unused_beep_cfg = ^BEEP_CYCLES;
  assign io.beep         = 1'b0;
`endif

  assign io.min_tens   = m1;
  assign io.min_ones   = m0;
  assign io.sec_tens   = s1;
  assign io.sec_ones   = s0;
  assign io.timer_done = !time_nz;
  assign io.done_pulse = done_pulse_q;
  assign io.state      = state;

endmodule

// File: tb/tb_microwave_timer.sv
// Directed bench for microwave_timer with a scoreboard: stimulus queues the
// expected snapshot or done strobe, the negedge monitor pops and compares.
module tb_microwave_timer;
  import microwave_pkg::*;

`ifdef MW_BEEP_EN
  localparam logic B = 1'b1;
`else
  localparam logic B = 1'b0;
`endif

  typedef struct {
    string       name;
    logic [15:0] dig;
    logic        td;
    logic        dp;
    state_t      st;
    logic        bp;
  } snap_t;

  logic clk;
  logic reset;
  logic chk_req;
  int   n_cmp;
  int   n_bad;

  snap_t snapq[$];
  string doneq[$];

  microwave_timer_if io ();

  microwave_timer #(.TICK_DIV(4), .BEEP_CYCLES(3)) dut (
    .clk  (clk),
    .reset(reset),
    .io   (io)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Monitor: compares requested snapshots and every done strobe.
  always @(negedge clk) begin
    logic [15:0] got;
    got = {io.min_tens, io.min_ones, io.sec_tens, io.sec_ones};
    if (chk_req) begin
      n_cmp++;
      if (snapq.size() == 0) begin
        n_bad++;
        $display("FAIL snapshot: got request with empty expectation queue");
      end else begin
        snap_t e;
        e = snapq.pop_front();
        if (got !== e.dig || io.timer_done !== e.td || io.done_pulse !== e.dp ||
            io.state !== e.st || io.beep !== e.bp) begin
          n_bad++;
          $display("FAIL %s: got dig=%h td=%b dp=%b st=%0d beep=%b, want dig=%h td=%b dp=%b st=%0d beep=%b",
                   e.name, got, io.timer_done, io.done_pulse, io.state, io.beep,
                   e.dig, e.td, e.dp, e.st, e.bp);
        end
      end
    end
    if (io.done_pulse === 1'b1) begin
      n_cmp++;
      if (doneq.size() == 0) begin
        n_bad++;
        $display("FAIL unexpected_done: got done_pulse=1 dig=%h, want no done_pulse", got);
      end else begin
        string nm;
        nm = doneq.pop_front();
        if (got !== 16'h0000 || io.timer_done !== 1'b1) begin
          n_bad++;
          $display("FAIL %s_done: got dig=%h td=%b, want dig=0000 td=1", nm, got, io.timer_done);
        end
      end
    end
  end

  task automatic clk_n(input int unsigned n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic press(input logic [3:0] d);
    io.key_digit = d;
    io.key_valid = 1'b1;
    @(posedge clk);
    #1;
    io.key_valid = 1'b0;
  endtask

  task automatic snap(input string nm, input logic [15:0] d, input logic td,
                      input logic dp, input state_t st, input logic bp);
    snap_t e;
    e.name = nm; e.dig = d; e.td = td; e.dp = dp; e.st = st; e.bp = bp;
    snapq.push_back(e);
    chk_req = 1'b1;
    @(negedge clk);
    #1;
    chk_req = 1'b0;
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    chk_req = 1'b0;
    reset = 1'b1;
    io.key_digit = '0;
    io.key_valid = 1'b0;
    io.clear = 1'b0;
    io.mag_on = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    snap("reset", 16'h0000, 1, 0, IDLE, 0);

    press(4'd1); press(4'd3); press(4'd0);
    snap("entry_0130", 16'h0130, 0, 0, SET, 0);
    press(4'hA);
    snap("key_A_ignored", 16'h0130, 0, 0, SET, 0);

    io.clear = 1'b1; clk_n(1); io.clear = 1'b0;
    snap("clear", 16'h0000, 1, 0, IDLE, 0);

    // 00:01 counts out on the fourth running clock, then the beep window
    press(4'd1);
    io.mag_on = 1'b1;
    doneq.push_back("count_0001");
    clk_n(4);
    snap("done_0001", 16'h0000, 1, 1, IDLE, 0);
    snap("after_done_1", 16'h0000, 1, 0, IDLE, B);
    snap("after_done_2", 16'h0000, 1, 0, IDLE, B);
    snap("after_done_3", 16'h0000, 1, 0, IDLE, B);
    snap("after_done_4", 16'h0000, 1, 0, IDLE, 0);
    io.mag_on = 1'b0;

    press(4'd1); press(4'd0); press(4'd0);
    io.mag_on = 1'b1;
    clk_n(4);
    snap("tick_0100", 16'h0059, 0, 0, RUN, 0);
    io.mag_on = 1'b0;
    snap("pause_0059", 16'h0059, 0, 0, SET, 0);

    press(4'd1); press(4'd0); press(4'd0); press(4'd0);
    io.mag_on = 1'b1;
    clk_n(4);
    snap("tick_1000", 16'h0959, 0, 0, RUN, 0);
    press(4'd5);
    snap("key_in_run", 16'h0959, 0, 0, RUN, 0);
    io.mag_on = 1'b0;
    io.clear = 1'b1; clk_n(1); io.clear = 1'b0;
    snap("clear2", 16'h0000, 1, 0, IDLE, 0);

    // partial second survives a pause
    press(4'd5);
    io.mag_on = 1'b1; clk_n(2);
    io.mag_on = 1'b0; clk_n(10);
    snap("paused_0005", 16'h0005, 0, 0, SET, 0);
    io.mag_on = 1'b1; clk_n(1);
    snap("resume_1clk", 16'h0005, 0, 0, RUN, 0);
    snap("resume_2clk", 16'h0004, 0, 0, RUN, 0);
    io.mag_on = 1'b0;

    // clear coincides with the final tick of 00:01
    press(4'd0); press(4'd0); press(4'd0); press(4'd1);
    snap("load_0001", 16'h0001, 0, 0, SET, 0);
    io.mag_on = 1'b1; clk_n(3);
    io.clear = 1'b1; clk_n(1); io.clear = 1'b0;
    io.mag_on = 1'b0;
    snap("clear_vs_tick", 16'h0000, 1, 0, IDLE, 0);

    press(4'd2);
    io.mag_on = 1'b1; clk_n(2);
    reset = 1'b1; #2; reset = 1'b0;
    snap("reset_mid_run", 16'h0000, 1, 0, IDLE, 0);
    press(4'd7);
    snap("key_mag_on_idle", 16'h0000, 1, 0, IDLE, 0);
    io.mag_on = 1'b0;
    press(4'd7);
    snap("entry_0007", 16'h0007, 0, 0, SET, 0);

    clk_n(2);
    n_cmp++;
    if (doneq.size() != 0 || snapq.size() != 0) begin
      n_bad++;
      $display("FAIL queues_drained: got done=%0d snap=%0d pending, want 0 and 0",
               doneq.size(), snapq.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
